// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte producers share one uart_tx.
// Optional build macro UART_ARB_HDR_EN prefixes each payload with header byte {5'b11110, grant_id}.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic [2:0]           grant_id,
   output logic                 active,
   output logic                 timeout_err
);

   typedef enum logic [2:0] {
      IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE, GAP
   } state_t;

   state_t               state, state_nx;
   logic [2:0]           rr_ptr, rr_ptr_nx;
   logic [NUM_REQ-1:0]   req_ready_nx;
   logic [7:0]           tx_data_nx;
   logic                 tx_start_nx;
   logic [2:0]           grant_id_nx;
   logic                 timeout_nx;
   logic [1:0]           wait_cnt, wait_cnt_nx;
   logic [7:0]           gap_cnt, gap_cnt_nx;
   logic                 hdr_phase, hdr_phase_nx;
   logic [7:0]           payload, payload_nx;

   logic [2:0]           winner;
   logic                 found;
   logic                 valid_g;
   logic [7:0]           data_g;
   logic [NUM_REQ-1:0]   onehot_g;

   // Two ascending passes: indices at/above rr_ptr first, then the wrapped-around ones.
   always_comb begin
      winner = rr_ptr;
      found  = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req_valid[j] && (3'(j) >= rr_ptr)) begin
            winner = 3'(j);
            found  = 1'b1;
         end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && req_valid[j] && (3'(j) < rr_ptr)) begin
            winner = 3'(j);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      valid_g  = 1'b0;
      data_g   = 8'h00;
      onehot_g = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (3'(j) == grant_id) begin
            valid_g     = req_valid[j];
            data_g      = req_data[8*j +: 8];
            onehot_g[j] = 1'b1;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx     = state;
      rr_ptr_nx    = rr_ptr;
      req_ready_nx = '0;
      tx_data_nx   = tx_data;
      tx_start_nx  = 1'b0;
      grant_id_nx  = grant_id;
      timeout_nx   = 1'b0;
      wait_cnt_nx  = wait_cnt;
      gap_cnt_nx   = gap_cnt;
      hdr_phase_nx = hdr_phase;
      payload_nx   = payload;
      case (state)
         IDLE: begin
            if (!tx_busy && (|req_valid)) begin
               grant_id_nx = winner;
               state_nx    = GRANT;
            end
         end
         GRANT: begin
            if (valid_g) begin
               req_ready_nx = onehot_g;
               payload_nx   = data_g;
               rr_ptr_nx    = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
               tx_start_nx  = 1'b1;
               state_nx     = START;
`ifdef UART_ARB_HDR_EN
               tx_data_nx   = {5'b11110, grant_id};
               hdr_phase_nx = 1'b1;
`else
               tx_data_nx   = data_g;
`endif
            end else begin
               state_nx = IDLE;
            end
         end
         START: begin
            wait_cnt_nx = 2'd0;
            state_nx    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nx = WAIT_DONE;
            end else if (wait_cnt == 2'd3) begin
               // A header that never started drops its payload as well.
               timeout_nx   = 1'b1;
               hdr_phase_nx = 1'b0;
               state_nx     = IDLE;
            end else begin
               wait_cnt_nx = wait_cnt + 2'd1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (hdr_phase) begin
                  hdr_phase_nx = 1'b0;
                  tx_data_nx   = payload;
                  tx_start_nx  = 1'b1;
                  state_nx     = START;
               end else if (GAP_CYCLES > 0) begin
                  gap_cnt_nx = 8'd0;
                  state_nx   = GAP;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nx = IDLE;
            else                               gap_cnt_nx = gap_cnt + 8'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         rr_ptr      <= 3'd0;
         req_ready   <= '0;
         tx_data     <= 8'h00;
         tx_start    <= 1'b0;
         grant_id    <= 3'd0;
         active      <= 1'b0;
         timeout_err <= 1'b0;
         wait_cnt    <= 2'd0;
         gap_cnt     <= 8'd0;
         hdr_phase   <= 1'b0;
         payload     <= 8'h00;
      end else begin
         state       <= state_nx;
         rr_ptr      <= rr_ptr_nx;
         req_ready   <= req_ready_nx;
         tx_data     <= tx_data_nx;
         tx_start    <= tx_start_nx;
         grant_id    <= grant_id_nx;
         active      <= (state_nx != IDLE);
         timeout_err <= timeout_nx;
         wait_cnt    <= wait_cnt_nx;
         gap_cnt     <= gap_cnt_nx;
         hdr_phase   <= hdr_phase_nx;
         payload     <= payload_nx;
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter GAP_CYCLES, default 0, idle clocks inserted after each completed byte before the next arbitration; legal range 0..255.
REQ-003 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port req_valid  input  NUM_REQ  bit i high = requester i has a byte pending.
REQ-006 Port req_data  input  NUM_REQ*8  requester i byte at bits [8i+7:8i].
REQ-007 Port req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-008 Port tx_data  output  8  byte to the uart_tx tx_data input.
REQ-009 Port tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-010 Port tx_busy  input  1  busy flag from uart_tx.
REQ-011 Port grant_id  output  3  index of the current/last granted requester.
REQ-012 Port active  output  1  high in every state except IDLE.
REQ-013 Port timeout_err  output  1  one-cycle pulse when uart_tx fails to go busy.

Function
REQ-014 States: IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE, GAP; all outputs are registered.
REQ-015 IDLE: if tx_busy=0 and any req_valid=1, select the winner round-robin, searching upward from rr_ptr with wrap at NUM_REQ-1 to 0, load grant_id, and go to GRANT; otherwise stay in IDLE.
REQ-016 GRANT (1 cycle): req_ready[grant_id]=1 and tx_data<=req_data of the winner, captured only if req_valid[grant_id] is still 1; rr_ptr<=(grant_id+1) mod NUM_REQ; go to START.
REQ-017 GRANT with req_valid[grant_id]=0: no capture, rr_ptr unchanged, no tx_start, return to IDLE.
REQ-018 START (1 cycle): tx_start=1; go to WAIT_BUSY. Latency from req_valid seen in IDLE to tx_start is 2 cycles.
REQ-019 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; if tx_busy stays 0 for 4 consecutive cycles, pulse timeout_err for 1 cycle and go to IDLE.
REQ-020 WAIT_DONE: on tx_busy=0 go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-021 GAP: count GAP_CYCLES clocks, then go to IDLE.
REQ-022 tx_data holds its value from GRANT until the next capture.
REQ-023 At most one req_ready bit is high in any cycle, and at most one grant is made per byte.
REQ-024 Requesters shall hold req_valid and req_data stable until their req_ready pulse.

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, rr_ptr=0, req_ready=0, tx_data=8'h00, tx_start=0, grant_id=0, active=0, timeout_err=0, gap counter=0.
REQ-026 Reset asserted mid-transfer abandons the byte without retry; the first arbitration after reset favours requester 0.

Configuration
REQ-027 Macro UART_ARB_HDR_EN defined: in GRANT the header byte {5'b11110, grant_id} is loaded into tx_data.
REQ-028 With UART_ARB_HDR_EN defined: after the header byte completes WAIT_DONE, the captured payload is sent by a second START/WAIT_BUSY/WAIT_DONE pass, and GAP follows only the payload.
REQ-029 With UART_ARB_HDR_EN defined: req_ready still pulses once per payload, and a timeout on the header skips the payload.
REQ-030 Macro UART_ARB_HDR_EN undefined: payload only, one tx_start per grant.

Verification
REQ-031 Requester 2 only, req_data=0xA5 -> req_ready=4'b0100 for 1 cycle; tx_start 2 cycles after IDLE sees valid; tx_data=0xA5; grant_id=2; serial line decodes 0xA5.
REQ-032 After reset, all 4 valid with data 0x10..0x13 -> grant order 0,1,2,3, bytes 0x10,0x11,0x12,0x13. Then only 0 and 3 re-request after granting 1 (rr_ptr=2) -> 3 is granted before 0.
REQ-033 tx_busy tied 0 after tx_start -> timeout_err pulses exactly once, 4 cycles into WAIT_BUSY; returns to IDLE; active=0 the next cycle.
REQ-034 rst_n=0 for 1 cycle during WAIT_DONE -> all outputs at reset values at the next edge; next grant goes to the lowest valid index.
REQ-035 UART_ARB_HDR_EN defined, requester 1 sends 0x34 -> two tx_start pulses with tx_data 0xF1 then 0x34; single req_ready pulse on bit 1.
REQ-036 GAP_CYCLES=3, requesters 0 and 1 valid -> exactly 3 cycles from tx_busy falling to IDLE before requester 1 is granted; active stays high throughout.
